program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Boot-time stage that sits directly upstream of the single-cycle CPU.
- Receives a program image as a byte stream over a valid/ready handshake and assembles 32-bit little-endian instruction words.
- Writes each word into instruction memory at successive word-aligned byte addresses.
- Holds the CPU in reset until the whole image has loaded and its checksum matches.

Parameters:
- MAX_WORDS, 1024: largest accepted word count; a header count above this is an error.
- BASE_ADDR, 32'h0000_0000: byte address of the first word written. The CPU fetches from this address after release.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  source has a byte on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction-memory write strobe, one-cycle pulse per word.
- imem_addr  output  32  byte address of the word being written.
- imem_wdata  output  32  assembled instruction word.
- cpu_reset  output  1  drives the CPU reset; high until the load completes successfully.
- done  output  1  load complete and checksum good; sticky.
- error  output  1  oversize count or checksum mismatch; sticky.
- words_loaded  output  16  number of words written so far.

Behaviour:
- Clock and reset: one clock, clock; reset is synchronous and active-high, sampled on the rising edge.
- Byte transfer: a byte transfers on a rising edge where in_valid && in_ready. in_data is ignored otherwise.
- Stream format, in order:
  - count low byte, then count high byte (16-bit word count N);
  - N×4 data bytes, least-significant byte first within each word;
  - one checksum byte equal to the XOR of all data bytes (header excluded).
- States: LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
- in_ready is 1 in LEN_LO, LEN_HI, DATA and CHECK; 0 in DONE and ERROR. No other backpressure.
- State transitions:
  - LEN_LO: on accept, latch count[7:0] and go to LEN_HI.
  - LEN_HI: on accept, latch count[15:8]. Then:
    - N==0 → CHECK (checksum must be 0x00);
    - N>MAX_WORDS → ERROR;
    - otherwise → DATA.
  - DATA:
    - A 2-bit byte index places each accepted byte at bits [8i+7:8i] of a shift/assembly register.
    - Each accepted byte is XORed into an 8-bit running checksum, cleared in LEN_LO.
    - On accepting byte index 3: on the next cycle imem_we=1 for exactly one cycle, with imem_wdata = assembled word and imem_addr = BASE_ADDR + 4×words_loaded (pre-increment value). words_loaded increments on that same edge.
    - Back-to-back words are legal. A write pulse can coincide with acceptance of the next word's byte 0.
    - After the byte that completes word N, go to CHECK.
  - CHECK: on accept, compare in_data to the running checksum. Equal → DONE; unequal → ERROR.
  - DONE and ERROR: terminal until reset. in_valid is ignored.
- Output rules:
  - imem_we is never asserted outside the cycle after a word completes.
  - imem_addr and imem_wdata hold their last values when imem_we=0.
  - done=1 exactly while in DONE; error=1 exactly while in ERROR.
  - cpu_reset is registered as !(state==DONE), so it falls one cycle after DONE is entered.
  - cpu_reset never falls in ERROR.
- Arithmetic: address offset is words_loaded×4, computed modulo 2^32. words_loaded never exceeds N, so it never wraps.
- Reset values:
  - state=LEN_LO, in_ready=1 (combinational from state);
  - imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0;
  - cpu_reset=1, done=0, error=0, words_loaded=0;
  - checksum, byte index and count all 0.
- Reset mid-load: any cycle with reset=1 aborts immediately and applies the reset values above.
  - A pending write pulse is cancelled.
  - Words already written stay in memory, but the loader restarts expecting a new header.
- Bytes offered while in_valid=0 cycles are interleaved: state, index and checksum hold unchanged.

Test Plan:
- Nominal load, in_valid held high: stream 02 00 93 00 50 00 13 01 A0 00 71 → expected:
  - imem_we pulses twice: (addr 0x0, data 0x00500093) then (addr 0x4, data 0x00A00113);
  - words_loaded=2, done=1, error=0;
  - cpu_reset falls one cycle after done rises.
- Same stream with in_valid toggled 1/0 every cycle → identical writes and final state; each imem_we is exactly one cycle wide.
- Same stream with checksum byte 70 → both writes occur, then error=1, done=0, cpu_reset stays 1, in_ready=0.
- Empty image: stream 00 00 00 → no imem_we, done=1, words_loaded=0. Stream 00 00 01 → error=1.
- Oversize count with MAX_WORDS=1024: stream 01 04 → error=1 right after the second byte, no writes, further bytes not accepted.
- Reset asserted after 6 bytes of the nominal stream, then the full nominal stream resent → state restarts at LEN_LO with words_loaded=0; final result matches the nominal case with writes at 0x0 and 0x4.

Source files
------------

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot loader: byte stream to instruction memory, holds CPU reset until image verified
module program_loader #(
  parameter int          MAX_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  state_t      state, next_state;
  logic [15:0] count_q;
  logic [1:0]  byte_idx;
  logic [7:0]  checksum;
  logic [23:0] word_sr;
  logic        accept;
  logic [15:0] full_count;
  logic        last_word;

  assign accept     = in_valid && in_ready;
  assign full_count = {in_data, count_q[7:0]};
  assign last_word  = (words_loaded + 16'd1) == count_q;

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    case (state)
      LEN_LO: begin
        in_ready = 1'b1;
        if (accept) next_state = LEN_HI;
      end
      LEN_HI: begin
        in_ready = 1'b1;
        if (accept) begin
          if (full_count == 16'd0)                 next_state = CHECK;
          else if (full_count > 16'(MAX_WORDS))    next_state = ERROR;
          else                                     next_state = DATA;
        end
      end
      DATA: begin
        in_ready = 1'b1;
        if (accept && byte_idx == 2'd3 && last_word) next_state = CHECK;
      end
      CHECK: begin
        in_ready = 1'b1;
        if (accept) next_state = (in_data == checksum) ? DONE : ERROR;
      end
      DONE:    next_state = DONE;
      ERROR:   next_state = ERROR;
      default: next_state = ERROR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= LEN_LO;
    end else begin
      state <= next_state;
    end
  end

  // Write pulse, address and data are all registered on the edge that accepts byte 3.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q      <= 16'd0;
      byte_idx     <= 2'd0;
      checksum     <= 8'd0;
      word_sr      <= 24'd0;
      imem_we      <= 1'b0;
      imem_addr    <= BASE_ADDR;
      imem_wdata   <= 32'd0;
      words_loaded <= 16'd0;
      cpu_reset    <= 1'b1;
    end else begin
      imem_we   <= 1'b0;
      cpu_reset <= (state != DONE);
      if (accept) begin
        case (state)
          LEN_LO: begin
            count_q[7:0] <= in_data;
            checksum     <= 8'd0;
            byte_idx     <= 2'd0;
          end
          LEN_HI: count_q[15:8] <= in_data;
          DATA: begin
            checksum <= checksum ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_sr[7:0]   <= in_data;
              2'd1: word_sr[15:8]  <= in_data;
              2'd2: word_sr[23:16] <= in_data;
              default: begin
                imem_we      <= 1'b1;
                imem_wdata   <= {in_data, word_sr};
                imem_addr    <= BASE_ADDR + {14'd0, words_loaded, 2'b00};
                words_loaded <= words_loaded + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign done  = (state == DONE);
  assign error = (state == ERROR);

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int checks = 0;
  int failures = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          we_run = 0;
  int          max_run = 0;

  logic [7:0] nominal[11] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                              8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};

  program_loader #(.MAX_WORDS(1024), .BASE_ADDR(32'h0000_0000)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done),
    .error(error), .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
      we_run = we_run + 1;
      if (we_run > max_run) max_run = we_run;
    end else begin
      we_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    max_run = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    clear_log();
  endtask

  task automatic send(input logic [7:0] b, input bit toggle);
    in_valid = 1'b1;
    in_data = b;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    if (toggle) begin
      in_data = 8'hFF;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_nominal(input logic [7:0] csum, input bit toggle);
    for (int i = 0; i < 10; i++) send(nominal[i], toggle);
    send(csum, 1'b0);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check({tag, "_a0"}, wr_addr[0], 32'h0);
      check({tag, "_d0"}, wr_data[0], 32'h0050_0093);
      check({tag, "_a1"}, wr_addr[1], 32'h4);
      check({tag, "_d1"}, wr_data[1], 32'h00A0_0113);
    end
    check({tag, "_we_width"}, max_run, 1);
    check({tag, "_words"}, words_loaded, 16'd2);
  endtask

  initial begin
    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_we", imem_we, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_wdata", imem_wdata, 32'h0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_words", words_loaded, 0);

    // nominal, in_valid held high
    send_nominal(8'h71, 1'b0);
    check("nom_done", done, 1);
    check("nom_error", error, 0);
    check("nom_cpu_reset_lag", cpu_reset, 1);
    @(posedge clock); #1;
    check("nom_cpu_reset_fall", cpu_reset, 0);
    check("nom_in_ready", in_ready, 0);
    check_writes("nom");

    // in_valid toggled every cycle
    do_reset();
    send_nominal(8'h71, 1'b1);
    @(posedge clock); #1;
    check("tog_done", done, 1);
    check("tog_error", error, 0);
    check("tog_cpu_reset", cpu_reset, 0);
    check_writes("tog");

    // bad checksum
    do_reset();
    send_nominal(8'h70, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    check("bad_error", error, 1);
    check("bad_done", done, 0);
    check("bad_cpu_reset", cpu_reset, 1);
    check("bad_in_ready", in_ready, 0);
    check_writes("bad");

    // empty image, good checksum
    do_reset();
    send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h00, 1'b0);
    @(posedge clock); #1;
    check("empty_done", done, 1);
    check("empty_error", error, 0);
    check("empty_words", words_loaded, 0);
    check("empty_nwr", wr_addr.size(), 0);
    check("empty_cpu_reset", cpu_reset, 0);

    // empty image, bad checksum
    do_reset();
    send(8'h00, 1'b0); send(8'h00, 1'b0); send(8'h01, 1'b0);
    check("empty_bad_error", error, 1);
    check("empty_bad_done", done, 0);

    // oversize count 0x0401
    do_reset();
    send(8'h01, 1'b0); send(8'h04, 1'b0);
    check("over_error", error, 1);
    check("over_in_ready", in_ready, 0);
    for (int i = 0; i < 8; i++) send(8'h55, 1'b0);
    check("over_nwr", wr_addr.size(), 0);
    check("over_words", words_loaded, 0);
    check("over_cpu_reset", cpu_reset, 1);

    // reset mid-load after 6 bytes, then reload
    do_reset();
    for (int i = 0; i < 6; i++) send(nominal[i], 1'b0);
    do_reset();
    check("mid_words", words_loaded, 0);
    check("mid_we", imem_we, 0);
    check("mid_in_ready", in_ready, 1);
    check("mid_done", done, 0);
    send_nominal(8'h71, 1'b0);
    @(posedge clock); #1;
    check("mid_done_final", done, 1);
    check("mid_cpu_reset", cpu_reset, 0);
    check_writes("mid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
